// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command-bus arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    // 15 us at 50 MHz: 4096 rows every 64 ms
    localparam int REF_CYCLES_DEF = 750;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer with a sticky refresh-due flag.
module sdram_ref_timer
    import sdram_arb_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF,
    parameter int REF_CNT_W  = 10
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic run,
    input  logic pend_clr,
    output logic aref_pend
);

    localparam logic [REF_CNT_W-1:0] TC_VAL = REF_CNT_W'(REF_CYCLES - 1);

    logic [REF_CNT_W-1:0] cnt;
    logic                 tc;

    assign tc = run && (cnt == TC_VAL);

    always_ff @(posedge sclk) begin
        if (s_rst || !run) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A terminal count coinciding with the clear must not lose the new refresh.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            aref_pend <= 1'b0;
        end else if (tc) begin
            aref_pend <= 1'b1;
        end else if (pend_clr) begin
            aref_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM command bus to init, refresh, write or read and muxes its pins.
// Optional: define SDRAM_ARB_RR_EN for round-robin write/read arbitration.
//
// state | meaning
// INIT  | power-up sequencer owns the bus
// ARBIT | idle, NOP on the bus, picks next requester
// AREF  | auto-refresh controller owns the bus
// WRITE | write controller owns the bus
// READ  | read controller owns the bus
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF,
    parameter int REF_CNT_W  = 10
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    output logic        aref_pend,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [11:0] wr_addr,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [11:0] rd_addr,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_bank,
    output logic [11:0] sdram_addr
);

    arb_state_t  state, state_nxt;
    logic        pick_wr;
    logic [3:0]  cmd_mux;

    sdram_ref_timer #(
        .REF_CYCLES(REF_CYCLES),
        .REF_CNT_W (REF_CNT_W)
    ) u_ref_timer (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .run      (state != INIT),
        .pend_clr ((state == ARBIT) && aref_pend),
        .aref_pend(aref_pend)
    );

`ifdef SDRAM_ARB_RR_EN
    logic last_grant;  // 1 = write was granted most recently

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            last_grant <= 1'b0;
        end else if (state_nxt == WRITE) begin
            last_grant <= 1'b1;
        end else if (state_nxt == READ) begin
            last_grant <= 1'b0;
        end
    end

    assign pick_wr = wr_req && (!rd_req || !last_grant);
`else
    assign pick_wr = wr_req;
`endif

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:  if (init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (aref_pend) begin
                    state_nxt = AREF;
                end else if (pick_wr) begin
                    state_nxt = WRITE;
                end else if (rd_req) begin
                    state_nxt = READ;
                end
            end
            AREF:  if (aref_end) state_nxt = ARBIT;
            WRITE: if (wr_end)   state_nxt = ARBIT;
            READ:  if (rd_end)   state_nxt = ARBIT;
            default: state_nxt = INIT;
        endcase
    end

    // Grants are registered copies of the next state so they track the state exactly.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            aref_en <= (state_nxt == AREF);
            wr_en   <= (state_nxt == WRITE);
            rd_en   <= (state_nxt == READ);
        end
    end

    always_comb begin
        cmd_mux    = CMD_NOP;
        sdram_bank = 2'd0;
        sdram_addr = 12'd0;
        case (state)
            INIT: begin
                cmd_mux    = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                cmd_mux    = aref_cmd;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            READ: begin
                cmd_mux    = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Table-driven bench for sdram_arbiter with a short refresh interval.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [11:0] INIT_ADDR = 12'h400;
    localparam logic [3:0]  AREF_CMD  = 4'b0001;
    localparam logic [11:0] AREF_ADDR = 12'h123;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [1:0]  WR_BANK   = 2'd2;
    localparam logic [11:0] WR_ADDR   = 12'h0A5;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [1:0]  RD_BANK   = 2'd3;
    localparam logic [11:0] RD_ADDR   = 12'h3C3;

    logic        sclk = 1'b0;
    logic        s_rst, init_end, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic        aref_en, aref_pend, wr_en, rd_en;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 sclk = ~sclk;

    sdram_arbiter #(.REF_CYCLES(20), .REF_CNT_W(10)) dut (
        .sclk(sclk), .s_rst(s_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .aref_pend(aref_pend),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
        .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_bank(rd_bank), .rd_addr(rd_addr),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
    );

    // in = {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end}
    typedef struct {
        int         rep;
        logic [6:0] in;
        arb_state_t st;
        logic       pend;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int rep, input logic [6:0] in,
                           input arb_state_t st, input logic pend);
        vec_t v;
        v.rep = rep; v.in = in; v.st = st; v.pend = pend;
        vq.push_back(v);
    endtask

    function automatic logic [17:0] exp_bus(input arb_state_t st);
        case (st)
            INIT:    return {INIT_CMD, 2'd0, INIT_ADDR};
            AREF:    return {AREF_CMD, 2'd0, AREF_ADDR};
            WRITE:   return {WR_CMD, WR_BANK, WR_ADDR};
            READ:    return {RD_CMD, RD_BANK, RD_ADDR};
            default: return {4'b0111, 2'd0, 12'd0};
        endcase
    endfunction

    function automatic logic [17:0] act_bus();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input arb_state_t st, input logic pend);
        chk({tag, " aref_en"},   32'(aref_en),   32'(st == AREF));
        chk({tag, " wr_en"},     32'(wr_en),     32'(st == WRITE));
        chk({tag, " rd_en"},     32'(rd_en),     32'(st == READ));
        chk({tag, " aref_pend"}, 32'(aref_pend), 32'(pend));
        chk({tag, " bus"},       32'(act_bus()), 32'(exp_bus(st)));
    endtask

    initial begin
        int k;
        {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = 7'b1000000;
        init_cmd = INIT_CMD; init_addr = INIT_ADDR;
        aref_cmd = AREF_CMD; aref_addr = AREF_ADDR;
        wr_cmd = WR_CMD; wr_bank = WR_BANK; wr_addr = WR_ADDR;
        rd_cmd = RD_CMD; rd_bank = RD_BANK; rd_addr = RD_ADDR;

        add_vec( 2, 7'b1000000, INIT,  1'b0);  // reset
        add_vec( 9, 7'b0000000, INIT,  1'b0);
        add_vec( 1, 7'b0100000, ARBIT, 1'b0);  // init done, timer starts
        add_vec(19, 7'b0100000, ARBIT, 1'b0);
        add_vec( 1, 7'b0100000, ARBIT, 1'b1);  // first refresh due
        add_vec( 3, 7'b0100000, AREF,  1'b0);
        add_vec( 1, 7'b0100001, ARBIT, 1'b0);
        add_vec( 1, 7'b0110100, WRITE, 1'b0);  // both request, write wins
        add_vec( 1, 7'b0110110, WRITE, 1'b0);  // stray rd_end ignored
        add_vec( 1, 7'b0110100, WRITE, 1'b0);
        add_vec( 1, 7'b0101100, ARBIT, 1'b0);
        add_vec( 1, 7'b0100100, READ,  1'b0);
        add_vec( 1, 7'b0101100, READ,  1'b0);  // stray wr_end ignored
        add_vec( 1, 7'b0100100, READ,  1'b0);
        add_vec( 1, 7'b0100010, ARBIT, 1'b0);
        add_vec( 7, 7'b0110000, WRITE, 1'b0);
        add_vec( 3, 7'b0110000, WRITE, 1'b1);  // refresh due mid-burst
        add_vec( 1, 7'b0111000, ARBIT, 1'b1);
        add_vec( 1, 7'b0110000, AREF,  1'b0);  // refresh before pending write
        add_vec( 1, 7'b0110001, ARBIT, 1'b0);
        add_vec( 1, 7'b0110000, WRITE, 1'b0);
        add_vec( 1, 7'b0101100, ARBIT, 1'b0);
        add_vec( 2, 7'b0100100, READ,  1'b0);
        add_vec( 1, 7'b1100100, INIT,  1'b0);  // reset during read
        add_vec( 3, 7'b0000100, INIT,  1'b0);
        add_vec( 1, 7'b0100100, ARBIT, 1'b0);
        add_vec(19, 7'b0100100, READ,  1'b0);
        add_vec(19, 7'b0100100, READ,  1'b1);
        add_vec( 1, 7'b0100010, ARBIT, 1'b1);
        add_vec( 1, 7'b0100000, AREF,  1'b1);  // clear and terminal count together
        add_vec( 1, 7'b0100001, ARBIT, 1'b1);
        add_vec( 1, 7'b0100000, AREF,  1'b0);
        add_vec( 1, 7'b0100001, ARBIT, 1'b0);

        foreach (vq[i]) begin
            for (int r = 0; r < vq[i].rep; r++) begin
                {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = vq[i].in;
                @(posedge sclk);
                #1;
                chk_all($sformatf("v%0d.%0d", i, r), vq[i].st, vq[i].pend);
            end
        end

        // Grant latency from ARBIT, then live mux of a changing write command.
        {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = 7'b0110000;
        k = 0;
        while (wr_en !== 1'b1 && k < 8) begin
            @(posedge sclk);
            #1;
            k++;
        end
        chk("wr_grant_latency", 32'(k), 32'd1);
        wr_cmd = 4'b0011; wr_bank = 2'd1; wr_addr = 12'h5A0;
        #1;
        chk("wr_live_mux", 32'(act_bus()), 32'({4'b0011, 2'd1, 12'h5A0}));
        {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = 7'b0101000;
        @(posedge sclk);
        #1;
        chk("wr_drop", 32'(wr_en), 32'd0);
        chk("arbit_nop", 32'(act_bus()), 32'({4'b0111, 2'd0, 12'd0}));
        {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = 7'b0100001;
        @(posedge sclk);
        #1;
        chk("stray_aref_end", 32'({aref_en, wr_en, rd_en}), 32'd0);
        {s_rst, init_end, wr_req, wr_end, rd_req, rd_end, aref_end} = 7'b0100000;
        @(posedge sclk);
        #1;
        chk("idle_stays", 32'(act_bus()), 32'({4'b0111, 2'd0, 12'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
